// File: rtl/gate_response_checker.sv
// Response checker for the two-input gate library: scores (a,b,y) samples against a chosen gate.
// Optional first-failure capture is built when GATE_CHK_FIRST_FAIL_EN is defined.
module gate_response_checker #(
    parameter int CNT_W    = 8,
    parameter int NUM_VECS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_a,
    input  logic             s_b,
    input  logic             s_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       coverage,
    output logic             op_err,
    output logic             fail_valid,
    output logic             fail_a,
    output logic             fail_b,
    output logic             fail_y
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             op_err_q, op_err_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic             pass_q, pass_d;
    logic             busy_q, done_q, ready_q;
    logic             accept, exp_y, mismatch;

    always_comb begin
        exp_y = 1'b0;
        case (op_q)
            3'd0: exp_y = s_a & s_b;
            3'd1: exp_y = s_a | s_b;
            3'd2: exp_y = ~(s_a & s_b);
            3'd3: exp_y = ~(s_a | s_b);
            3'd4: exp_y = s_a ^ s_b;
            3'd5: exp_y = ~(s_a ^ s_b);
            default: exp_y = 1'b0;
        endcase
    end

    // start wins over a coincident handshake, so the sample is dropped
    assign accept   = s_valid && ready_q && !start;
    assign mismatch = op_err_q || (s_y != exp_y);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        op_err_d = op_err_q;
        vec_d    = vec_q;
        err_d    = err_q;
        cov_d    = cov_q;
        pass_d   = pass_q;
        if (start) begin
            state_d  = RUN;
            op_d     = op_sel;
            op_err_d = (op_sel > 3'd5);
            vec_d    = '0;
            err_d    = '0;
            cov_d    = '0;
            pass_d   = 1'b0;
        end else if (accept) begin
            vec_d = (vec_q == CNT_MAX) ? vec_q : vec_q + 1'b1;
            if (mismatch && err_q != CNT_MAX) begin
                err_d = err_q + 1'b1;
            end
            cov_d[{s_a, s_b}] = 1'b1;
            if (vec_q == LAST_IDX) begin
                state_d = DONE;
                pass_d  = (err_d == '0) && (cov_d == 4'hF) && !op_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            op_err_q <= 1'b0;
            vec_q    <= '0;
            err_q    <= '0;
            cov_q    <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            op_err_q <= op_err_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            cov_q    <= cov_d;
            pass_q   <= pass_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
            ready_q  <= (state_d == RUN);
        end
    end

    assign s_ready  = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign vec_cnt  = vec_q;
    assign err_cnt  = err_q;
    assign coverage = cov_q;
    assign op_err   = op_err_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic fv_q, fa_q, fb_q, fy_q;

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            fv_q <= 1'b0;
            fa_q <= 1'b0;
            fb_q <= 1'b0;
            fy_q <= 1'b0;
        end else if (accept && mismatch && !fv_q) begin
            fv_q <= 1'b1;
            fa_q <= s_a;
            fb_q <= s_b;
            fy_q <= s_y;
        end
    end

    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_y     = fy_q;
`else
    assign fail_valid = 1'b0;
    assign fail_a     = 1'b0;
    assign fail_b     = 1'b0;
    assign fail_y     = 1'b0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed, table-driven bench for gate_response_checker (default and CNT_W=2 instances).
module tb_gate_response_checker;
    logic       clk = 1'b0;
    logic       rst_n, start, s_valid, s_a, s_b, s_y;
    logic [2:0] op_sel;

    logic       s_ready, busy, done, pass, op_err, fail_valid, fail_a, fail_b, fail_y;
    logic [7:0] vec_cnt, err_cnt;
    logic [3:0] coverage;

    logic       z_ready, z_busy, z_done, z_pass, z_op_err, z_fv, z_fa, z_fb, z_fy;
    logic [1:0] z_vec, z_err;
    logic [3:0] z_cov;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_response_checker #(.CNT_W(8), .NUM_VECS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_y(s_y),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .coverage(coverage), .op_err(op_err), .fail_valid(fail_valid),
        .fail_a(fail_a), .fail_b(fail_b), .fail_y(fail_y)
    );

    gate_response_checker #(.CNT_W(2), .NUM_VECS(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
        .s_valid(s_valid), .s_ready(z_ready), .s_a(s_a), .s_b(s_b), .s_y(s_y),
        .busy(z_busy), .done(z_done), .pass(z_pass), .vec_cnt(z_vec), .err_cnt(z_err),
        .coverage(z_cov), .op_err(z_op_err), .fail_valid(z_fv),
        .fail_a(z_fa), .fail_b(z_fb), .fail_y(z_fy)
    );

    typedef struct {
        string             name;
        logic [2:0]        op;
        logic [0:3][2:0]   smp;     // each sample is {a,b,y}
        logic [7:0]        err;
        logic [3:0]        cov;
        logic              pass;
        logic              op_err;
        logic [3:0]        fail;    // {valid,a,b,y}
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] op);
        start  = 1'b1;
        op_sel = op;
        tick();
        start  = 1'b0;
    endtask

    task automatic send(input logic [2:0] abx);
        s_valid = 1'b1;
        {s_a, s_b, s_y} = abx;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_fail(input string name, input logic [3:0] exp);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk(name, 32'({fail_valid, fail_a, fail_b, fail_y}), 32'(exp));
`else
        chk(name, 32'({fail_valid, fail_a, fail_b, fail_y}), 32'(exp & 4'h0));
`endif
    endtask

    initial begin
        tbl[0] = '{"nor_ok",   3'd3, {3'b001, 3'b010, 3'b100, 3'b110}, 8'd0, 4'hF, 1'b1, 1'b0, 4'b0000};
        tbl[1] = '{"nor_flt",  3'd3, {3'b001, 3'b010, 3'b101, 3'b110}, 8'd1, 4'hF, 1'b0, 1'b0, 4'b1101};
        tbl[2] = '{"and_hole", 3'd0, {3'b000, 3'b000, 3'b000, 3'b000}, 8'd0, 4'h1, 1'b0, 1'b0, 4'b0000};
        tbl[3] = '{"rsv_op",   3'd6, {3'b001, 3'b010, 3'b100, 3'b110}, 8'd4, 4'hF, 1'b0, 1'b1, 4'b1001};
        tbl[4] = '{"xor_ok",   3'd4, {3'b000, 3'b011, 3'b101, 3'b110}, 8'd0, 4'hF, 1'b1, 1'b0, 4'b0000};
        tbl[5] = '{"nand_ok",  3'd2, {3'b001, 3'b011, 3'b101, 3'b110}, 8'd0, 4'hF, 1'b1, 1'b0, 4'b0000};
        tbl[6] = '{"or_2err",  3'd1, {3'b001, 3'b011, 3'b100, 3'b111}, 8'd2, 4'hF, 1'b0, 1'b0, 4'b1001};

        rst_n = 1'b0; start = 1'b0; op_sel = 3'd0;
        s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_y = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_operr", 32'(op_err), 32'd0);
        chk("rst_cnts", 32'({vec_cnt, err_cnt, coverage}), 32'd0);
        chk_fail("rst_fail", 4'b0000);

        // s_valid ignored in IDLE
        s_valid = 1'b1; s_a = 1'b1; s_b = 1'b1; s_y = 1'b0;
        tick(); tick();
        s_valid = 1'b0;
        chk("idle_ready", 32'(s_ready), 32'd0);
        chk("idle_vec", 32'(vec_cnt), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_start(tbl[i].op);
            chk({tbl[i].name, "_busy0"}, 32'({busy, s_ready, done}), 32'b110);
            for (int k = 0; k < 4; k++) begin
                send(tbl[i].smp[k]);
                if (k == 0) chk({tbl[i].name, "_vec1"}, 32'(vec_cnt), 32'd1);
            end
            chk({tbl[i].name, "_done"}, 32'({done, busy, s_ready}), 32'b100);
            chk({tbl[i].name, "_vec"}, 32'(vec_cnt), 32'd4);
            chk({tbl[i].name, "_err"}, 32'(err_cnt), 32'(tbl[i].err));
            chk({tbl[i].name, "_cov"}, 32'(coverage), 32'(tbl[i].cov));
            chk({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].pass));
            chk({tbl[i].name, "_operr"}, 32'(op_err), 32'(tbl[i].op_err));
            chk_fail({tbl[i].name, "_fail"}, tbl[i].fail);
        end

        // s_valid ignored in DONE; results held
        send(3'b111);
        chk("done_hold", 32'({done, vec_cnt, err_cnt}), 32'({1'b1, 8'd4, 8'd2}));

        // start coincident with a handshake restarts and drops the sample
        do_start(3'd3);
        send(3'b001);
        send(3'b011);
        s_valid = 1'b1; {s_a, s_b, s_y} = 3'b101;
        do_start(3'd3);
        s_valid = 1'b0;
        chk("restart_cnts", 32'({vec_cnt, err_cnt, coverage}), 32'd0);
        chk("restart_busy", 32'({busy, s_ready, pass}), 32'b110);
        chk_fail("restart_fail", 4'b0000);

        // reset mid-session
        send(3'b101);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_flags", 32'({busy, done, pass, s_ready, op_err}), 32'd0);
        chk("midrst_cnts", 32'({vec_cnt, err_cnt, coverage}), 32'd0);
        chk_fail("midrst_fail", 4'b0000);

        // saturation instance: XOR with three mismatches
        do_start(3'd4);
        send(3'b001);
        send(3'b010);
        send(3'b111);
        chk("sat_err", 32'(z_err), 32'd3);
        chk("sat_vec", 32'(z_vec), 32'd3);
        chk("sat_done", 32'({z_done, z_pass, z_ready}), 32'b100);
        chk("sat_main_not_done", 32'({done, vec_cnt}), 32'({1'b0, 8'd3}));
        send(3'b001);
        chk("sat_hold", 32'({z_err, z_vec}), 32'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable response checker for the two-input gate library. It consumes (a, b, y) sample triples from a gate under test over a valid/ready handshake, computes the expected output for a selected gate function, and counts vectors, mismatches and input-combination coverage. It reports pass/fail when a fixed number of vectors has been checked. It is the receiving end of the directed-stimulus flow used for the gate blocks, and lets gate checks run on hardware without a simulator.

## Interface
- CNT_W, default 8, width of the vector and error counters
- NUM_VECS, default 4, number of accepted samples per session; legal range 1..2^CNT_W-1
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins a new session and clears all results
- op_sel  in  3  gate function, latched on start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6–7 reserved
- s_valid  in  1  sample valid
- s_ready  out  1  checker accepts a sample
- s_a, s_b  in  1  gate inputs applied
- s_y  in  1  gate output observed
- busy  out  1  session in progress
- done  out  1  session complete; held until the next start or reset
- pass  out  1  valid while done
- vec_cnt  out  CNT_W  accepted samples
- err_cnt  out  CNT_W  mismatching samples
- coverage  out  4  bit {a,b} set once that combination has been accepted
- op_err  out  1  latched op_sel is reserved
- fail_valid, fail_a, fail_b, fail_y  out  1 each  first failing sample (macro only)

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE → RUN on start. DONE → RUN on start. RUN → RUN on start, which restarts the session.
- RUN → DONE on the edge that accepts sample number NUM_VECS.
- On a start edge:
  - vec_cnt, err_cnt, coverage, pass and fail_* are cleared.
  - op_sel is latched.
  - op_err is set to (op_sel > 5).
- s_ready = 1 only in RUN. This is a registered state decode, not driven from s_valid.
- A sample is accepted when s_valid && s_ready at the edge. On acceptance:
  - vec_cnt increments.
  - coverage[{s_a,s_b}] is set.
  - If s_y differs from expected(op, s_a, s_b), err_cnt increments.
  - With a reserved op, every accepted sample counts as a mismatch.
- Counters saturate at all-ones; they never wrap.
- start has priority over a simultaneous handshake. The sample is discarded and not counted.
- In IDLE and DONE, s_valid is ignored.
- pass = done && err_cnt == 0 && coverage == 4'b1111 && !op_err. pass is 0 whenever done is 0.

## Timing
- Reset values:
  - busy = 0, done = 0, pass = 0, s_ready = 0, op_err = 0
  - vec_cnt = 0, err_cnt = 0, coverage = 0
  - fail_* = 0
- Every output is registered.
- An accepted sample is reflected in vec_cnt, err_cnt and coverage on the cycle after the accepting edge.
- busy and s_ready assert on the cycle after start.
- Throughput is one sample per cycle.
- done and pass assert on the cycle after the final accept, the same cycle the final counts are visible. s_ready drops on that same cycle.
- rst_n low mid-session returns the block to IDLE with reset values at the next edge. rst_n has priority over start.

## Configuration
- GATE_CHK_FIRST_FAIL_EN defined:
  - On the first mismatching accept of a session, fail_a, fail_b and fail_y capture the sample and fail_valid is set.
  - Later mismatches do not overwrite the capture.
  - start and reset clear all four fail_* outputs.
- GATE_CHK_FIRST_FAIL_EN undefined:
  - fail_valid, fail_a, fail_b and fail_y are tied to 0 and no capture logic is built.
  - Ports remain present.

## Test plan
- NOR, NUM_VECS=4: start with op_sel=3, then accept (0,0,1), (0,1,0), (1,0,0), (1,1,0) → vec_cnt=4, err_cnt=0, coverage=4'b1111, done=1, pass=1.
- NOR with one fault: the sample (1,0,1) replaces (1,0,0) → err_cnt=1, pass=0. With the macro defined: fail_valid=1 and fail_a/b/y = 1/0/1.
- Coverage hole, NUM_VECS=4, AND: (0,0,0) sent four times → err_cnt=0, coverage=4'b0001, pass=0.
- Back-pressure and priority:
  - s_valid high in IDLE → s_ready=0, vec_cnt stays 0.
  - start coincident with a handshake in RUN → that sample is not counted, and counters read 0 the next cycle.
- Reserved op and reset: op_sel=6 with 4 samples → op_err=1, err_cnt=4, pass=0. rst_n low for 1 cycle mid-RUN → all outputs return to reset values and s_ready=0.
- Saturation, CNT_W=2, NUM_VECS=3: XOR with three mismatching samples → err_cnt=3, vec_cnt=3, done=1, with no wrap observed.
